// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle control unit for the RISC-V core. Accepts one decoded
//   instruction per valid/ready handshake and walks it through
//   DECODE -> EXEC -> (MEM) -> (WB). It drives ALU-operation select,
//   memory strobes, branch/jump and register-write enables. It also flags
//   illegal opcodes and memory timeouts, and counts retired instructions.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only in FETCH)
//   opcode, funct3,     instruction fields, captured on the handshake edge
//   funct7_b5
//   mem_ready           data memory completed the current access
//   reg_write, mem_read, mem_write, branch, jump, alu_op
//                       per-state control outputs
//   retire, illegal_instr, mem_fault
//                       single-cycle event pulses
//   instret             retired-instruction counter (wraps)
module multicycle_control_fsm #(
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_b5,
  input  logic                mem_ready,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                retire,
  output logic                illegal_instr,
  output logic                mem_fault,
  output logic [CNT_W-1:0]    instret
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // The timeout counter never needs to hold more than MEM_TIMEOUT-1.
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            trap_mem_q;   // 1: trap caused by memory timeout, 0: illegal opcode
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic            b5_q;
  logic [3:0]      alu_code;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [6:0] op, input logic [2:0] f3,
                                         input logic b5);
    logic [3:0] sel;
    sel = ALU_ADD;
    if ((op == OP_R) || (op == OP_I)) begin
      case (f3)
        3'b000:  sel = ((op == OP_R) && b5) ? ALU_SUB : ALU_ADD;
        3'b001:  sel = ALU_SLL;
        3'b010:  sel = ALU_SLT;
        3'b011:  sel = ALU_SLTU;
        3'b100:  sel = ALU_XOR;
        3'b101:  sel = b5 ? ALU_SRA : ALU_SRL;
        3'b110:  sel = ALU_OR;
        default: sel = ALU_AND;
      endcase
    end else if (op == OP_BEQ) begin
      sel = ALU_SUB;
    end else if (op == OP_LUI) begin
      sel = ALU_PASS;
    end
    return sel;
  endfunction

  // Instruction fields are datapath values: captured on the handshake, never reset.
  always_ff @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      op_q <= opcode;
      f3_q <= funct3;
      b5_q <= funct7_b5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      trap_mem_q <= 1'b0;
      instret    <= '0;
    end else begin
      state <= state_nxt;
      if ((state != S_MEM) && (state_nxt == S_MEM)) begin
        to_cnt <= '0;
      end else if ((state == S_MEM) && !mem_ready) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (state_nxt == S_TRAP) begin
        trap_mem_q <= (state == S_MEM);
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    instr_ready   = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    mem_fault     = 1'b0;
    alu_code      = ALU_ADD;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = is_legal(op_q) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_code = alu_sel(op_q, f3_q, b5_q);
        case (op_q)
          OP_BEQ: begin
            branch    = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_JAL: begin
            jump      = 1'b1;
            state_nxt = S_WB;
          end
          OP_LW, OP_SW: state_nxt = S_MEM;
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        // A late mem_ready on the final allowed cycle still completes normally.
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            state_nxt = S_WB;
          end else begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        illegal_instr = !trap_mem_q;
        mem_fault     = trap_mem_q;
        state_nxt     = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int T = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct packed {
    logic       rdy;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jp;
    logic       ret;
    logic       ill;
    logic       flt;
    logic [4:0] alu;
    logic [3:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_b5 = 1'b0;
  logic       mem_ready = 1'b0;
  logic       reg_write, mem_read, mem_write, branch, jump;
  logic [4:0] alu_op;
  logic       retire, illegal_instr, mem_fault;
  logic [3:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t       obs;
  obs_t       exp_q[$];
  logic       mrdy_q[$];
  logic [3:0] exp_cnt = '0;

  logic [6:0] legal_ops [7] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_LUI};
  logic [4:0] f3_base   [8] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};

  multicycle_control_fsm #(.ALU_OP_W(5), .MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5), .mem_ready(mem_ready),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_op(alu_op), .retire(retire),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {instr_ready, reg_write, mem_read, mem_write, branch, jump,
                retire, illegal_instr, mem_fault, alu_op, instret};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic [6:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] m_alu(input logic [6:0] op, input logic [2:0] f3,
                                       input logic b5);
    logic [4:0] a;
    a = 5'd0;
    if (op == OP_R || op == OP_I) begin
      a = f3_base[f3];
      if (f3 == 3'd0 && op == OP_R && b5) a = 5'd1;
      if (f3 == 3'd5 && b5) a = 5'd7;
    end else if (op == OP_BEQ) begin
      a = 5'd1;
    end else if (op == OP_LUI) begin
      a = 5'd10;
    end
    return a;
  endfunction

  task automatic push(input obs_t e, input logic m);
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    mrdy_q.push_back(m);
    if (e.ret) exp_cnt = exp_cnt + 4'd1;
  endtask

  // Expected per-cycle outputs from the cycle after acceptance up to (not
  // including) the next FETCH cycle, plus the mem_ready to drive each cycle.
  task automatic build_expected(input logic [6:0] op, input logic [2:0] f3,
                                input logic b5, input int waits);
    obs_t e;
    logic is_lw, is_sw;
    exp_q.delete();
    mrdy_q.delete();
    is_lw = (op == OP_LW);
    is_sw = (op == OP_SW);
    e = '0;
    push(e, 1'b0);
    if (!m_legal(op)) begin
      e.ill = 1'b1;
      push(e, 1'b0);
      return;
    end
    e.alu = m_alu(op, f3, b5);
    e.br  = (op == OP_BEQ);
    e.ret = (op == OP_BEQ);
    e.jp  = (op == OP_JAL);
    push(e, 1'b0);
    if (op == OP_BEQ) return;
    if (is_lw || is_sw) begin
      if (waits < T) begin
        for (int j = 0; j <= waits; j++) begin
          e = '0;
          e.mr  = is_lw;
          e.mw  = is_sw;
          e.ret = is_sw && (j == waits);
          push(e, j == waits);
        end
        if (is_sw) return;
      end else begin
        for (int j = 0; j < T; j++) begin
          e = '0;
          e.mr = is_lw;
          e.mw = is_sw;
          push(e, 1'b0);
        end
        e = '0;
        e.flt = 1'b1;
        push(e, 1'b0);
        return;
      end
    end
    e = '0;
    e.rw  = 1'b1;
    e.ret = 1'b1;
    push(e, 1'b0);
  endtask

  // Assumes the DUT is in FETCH at the next falling edge.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic b5, input int waits, input int idles);
    obs_t f;
    f = '0;
    f.rdy = 1'b1;
    f.cnt = exp_cnt;
    build_expected(op, f3, b5, waits);
    for (int k = 0; k <= idles; k++) begin
      @(negedge clk);
      instr_valid = (k == idles);
      opcode      = (k == idles) ? op : 7'($urandom);
      funct3      = (k == idles) ? f3 : 3'($urandom);
      funct7_b5   = (k == idles) ? b5 : 1'($urandom);
      mem_ready   = 1'($urandom);
      #1;
      n_tests++;
      if (obs !== f) begin
        n_fail++;
        $display("FAIL %s fetch%0d: got %h want %h", name, k, obs, f);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      instr_valid = 1'($urandom);
      opcode      = 7'($urandom);
      funct3      = 3'($urandom);
      funct7_b5   = 1'($urandom);
      mem_ready   = mrdy_q[i];
      #1;
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got %h want %h", name, i + 1, obs, exp_q[i]);
      end
    end
    instr_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t f;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_release_c1: got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk);
    #1;
    f = '0;
    f.rdy = 1'b1;
    n_tests++;
    if (obs !== f) begin
      n_fail++;
      $display("FAIL reset_release_c2: got %h want %h", obs, f);
    end
    exp_cnt = '0;
  endtask

  task automatic test_alu_decode();
    logic [6:0] op;
    run_instr("r_sub", OP_R, 3'b000, 1'b1, 0, 0);
    run_instr("i_add", OP_I, 3'b000, 1'b1, 0, 1);
    run_instr("r_sra", OP_R, 3'b101, 1'b1, 0, 0);
    run_instr("i_srl", OP_I, 3'b101, 1'b0, 0, 0);
    run_instr("lui", OP_LUI, 3'($urandom), 1'($urandom), 0, 0);
    run_instr("jal", OP_JAL, 3'($urandom), 1'($urandom), 0, 0);
    for (int n = 0; n < 12; n++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_R : OP_I;
      run_instr("alu_rand", op, 3'($urandom), 1'($urandom), 0, $urandom_range(0, 2));
    end
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", OP_LW, 3'b010, 1'b0, 3, 0);
    run_instr("lw_nowait", OP_LW, 3'b010, 1'b0, 0, 0);
    run_instr("sw_wait1", OP_SW, 3'b010, 1'b0, 1, 0);
  endtask

  task automatic test_sw_timeout();
    run_instr("sw_timeout", OP_SW, 3'b010, 1'b0, 50, 0);
    run_instr("lw_timeout", OP_LW, 3'b010, 1'b0, 50, 1);
  endtask

  task automatic test_timeout_race();
    run_instr("sw_race", OP_SW, 3'b010, 1'b0, T - 1, 0);
    run_instr("lw_race", OP_LW, 3'b010, 1'b0, T - 1, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_system", 7'b1110011, 3'b000, 1'b0, 0, 0);
    run_instr("illegal_zero", 7'b0000000, 3'b000, 1'b0, 0, 0);
    run_instr("after_illegal", OP_R, 3'b111, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 6)];
      run_instr("random", op, 3'($urandom), 1'($urandom), $urandom_range(0, 6),
                $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t e;
    @(negedge clk);
    instr_valid = 1'b1;
    opcode      = OP_LW;
    funct3      = 3'b010;
    mem_ready   = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    e = '0;
    e.mr  = 1'b1;
    e.cnt = exp_cnt;
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_mid_mem_pre: got %h want %h", obs, e);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL rst_mid_mem_async: got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (obs !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL rst_mid_mem_release_c1: got %h want %h", obs, obs_t'(0));
    end
    @(negedge clk);
    #1;
    e = '0;
    e.rdy = 1'b1;
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_mid_mem_release_c2: got %h want %h", obs, e);
    end
    exp_cnt = '0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) begin
      run_instr("beq_wrap", OP_BEQ, 3'($urandom), 1'($urandom), 0, 0);
    end
    run_instr("after_wrap", OP_I, 3'b100, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_lw_wait();
    test_sw_timeout();
    test_timeout_race();
    test_illegal();
    test_random();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
